dac_ramp_gen: RTL and testbench

Single-channel sweep generator that sits directly upstream of the fast-DAC DDR output stage. It feeds that stage's per-channel data/enable/reset inputs with a programmable sawtooth, or a triangle when compiled in. Sample rate, span, step and sweep count are set by software-side registers. One instance is used per DAC channel (A, B).

---
 rtl/dac_ramp_gen_if.sv | 36 +++
 rtl/dac_ramp_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_dac_ramp_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ramp_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_ramp_gen_if
// Purpose  : Control/status and DAC-side signal bundle for dac_ramp_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_ramp_gen_if #(
  parameter int DATA_SIZE = 14,
  parameter int DIV_SIZE  = 16,
  parameter int CNT_SIZE  = 16
);
  logic                 start_i;
  logic                 stop_i;
  logic [DATA_SIZE-1:0] min_i;
  logic [DATA_SIZE-1:0] max_i;
  logic [DATA_SIZE-1:0] step_i;
  logic [DIV_SIZE-1:0]  div_i;
  logic [CNT_SIZE-1:0]  count_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [DATA_SIZE-1:0] dac_dat_o;
  logic                 dac_dat_en_o;
  logic                 dac_dat_rst_o;

  modport master (
    output start_i, stop_i, min_i, max_i, step_i, div_i, count_i,
    input  busy_o, done_o, err_o, dac_dat_o, dac_dat_en_o, dac_dat_rst_o
  );

  modport slave (
    input  start_i, stop_i, min_i, max_i, step_i, div_i, count_i,
    output busy_o, done_o, err_o, dac_dat_o, dac_dat_en_o, dac_dat_rst_o
  );
endinterface
`default_nettype wire

// File: rtl/dac_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module   : dac_ramp_gen
// Purpose  : Per-channel sawtooth sweep source for the fast-DAC output stage;
//            define DAC_RAMP_BOUNCE_EN to build the triangle variant.
// Revision : 1.0 - initial release
// ============================================================================
module dac_ramp_gen #(
  parameter int DATA_SIZE = 14,
  parameter int DIV_SIZE  = 16,
  parameter int CNT_SIZE  = 16
) (
  input  logic          dac_clk_i,
  input  logic          dac_rst_i,
  dac_ramp_gen_if.slave bus
);

  // Two guard bits: value + a full-range unsigned step can never wrap.
  localparam int W = DATA_SIZE + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic signed [DATA_SIZE-1:0]  r_min;
  logic signed [DATA_SIZE-1:0]  r_max;
  logic signed [DATA_SIZE-1:0]  r_value;
  logic signed [DATA_SIZE-1:0]  r_dat;
  logic [DATA_SIZE-1:0]         r_step;
  logic [DIV_SIZE-1:0]          r_div;
  logic [DIV_SIZE-1:0]          r_div_cnt;
  logic [CNT_SIZE-1:0]          r_count;
  logic [CNT_SIZE-1:0]          r_sweep_cnt;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_err;
  logic                         r_dat_en;
  logic                         r_dat_rst;

  logic                         w_accept;
  logic                         w_reject;
  logic                         w_strobe;
  logic                         w_abort;
  logic                         w_wrap;
  logic signed [DATA_SIZE-1:0]  w_value_nxt;
  logic [CNT_SIZE-1:0]          w_sweep_nxt;
  logic signed [W-1:0]          w_val_x;
  logic signed [W-1:0]          w_max_x;
  logic signed [W-1:0]          w_up;

`ifdef DAC_RAMP_BOUNCE_EN
  logic                         r_dir;
  logic                         r_at_min;
  logic                         w_dir_nxt;
  logic                         w_at_min_nxt;
  logic signed [W-1:0]          w_min_x;
  logic signed [W-1:0]          w_dn;

  assign w_min_x = {{2{r_min[DATA_SIZE-1]}}, r_min};
  assign w_dn    = w_val_x - {2'b00, r_step};
`endif

  assign w_val_x = {{2{r_value[DATA_SIZE-1]}}, r_value};
  assign w_max_x = {{2{r_max[DATA_SIZE-1]}}, r_max};
  assign w_up    = w_val_x + {2'b00, r_step};

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_strobe     = 1'b0;
    w_abort      = 1'b0;
    w_wrap       = 1'b0;
    w_value_nxt  = r_value;
    w_sweep_nxt  = r_sweep_cnt;
`ifdef DAC_RAMP_BOUNCE_EN
    w_dir_nxt    = r_dir;
    w_at_min_nxt = r_at_min;
`endif
    case (r_state)
      S_IDLE: begin
        // Start together with stop is dropped silently, no error report.
        if (bus.start_i && !bus.stop_i) begin
          if ((bus.step_i == '0) || ($signed(bus.min_i) > $signed(bus.max_i))) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.stop_i) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_div_cnt == r_div) begin
          w_strobe = 1'b1;
`ifdef DAC_RAMP_BOUNCE_EN
          // A sweep is credited when the returning minimum sample goes out.
          if (r_at_min) begin
            w_wrap       = 1'b1;
            w_at_min_nxt = 1'b0;
          end
          if (!r_dir) begin
            if (w_up >= w_max_x) begin
              w_value_nxt = r_max;
              w_dir_nxt   = 1'b1;
            end else begin
              w_value_nxt = w_up[DATA_SIZE-1:0];
            end
          end else begin
            if (w_dn <= w_min_x) begin
              w_value_nxt  = r_min;
              w_dir_nxt    = 1'b0;
              w_at_min_nxt = 1'b1;
            end else begin
              w_value_nxt = w_dn[DATA_SIZE-1:0];
            end
          end
`else
          if (w_up > w_max_x) begin
            w_value_nxt = r_min;
            w_wrap      = 1'b1;
          end else begin
            w_value_nxt = w_up[DATA_SIZE-1:0];
          end
`endif
          if (w_wrap) begin
            w_sweep_nxt = r_sweep_cnt + 1'b1;
            if ((r_count != '0) && (w_sweep_nxt == r_count)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_min       <= '0;
      r_max       <= '0;
      r_step      <= '0;
      r_div       <= '0;
      r_count     <= '0;
      r_value     <= '0;
      r_div_cnt   <= '0;
      r_sweep_cnt <= '0;
      r_dat       <= '0;
      r_dat_en    <= 1'b0;
      r_dat_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef DAC_RAMP_BOUNCE_EN
      r_dir       <= 1'b0;
      r_at_min    <= 1'b0;
`endif
    end else begin
      r_err     <= w_reject;
      r_dat_rst <= w_abort;
      r_dat_en  <= w_strobe;
      r_done    <= (r_state == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_strobe) begin
        r_dat <= r_value;
      end
      if (w_accept) begin
        r_min       <= $signed(bus.min_i);
        r_max       <= $signed(bus.max_i);
        r_step      <= bus.step_i;
        r_div       <= bus.div_i;
        r_count     <= bus.count_i;
        r_value     <= $signed(bus.min_i);
        r_div_cnt   <= '0;
        r_sweep_cnt <= '0;
`ifdef DAC_RAMP_BOUNCE_EN
        r_dir       <= 1'b0;
        r_at_min    <= 1'b0;
`endif
      end else if ((r_state == S_RUN) && !bus.stop_i) begin
        if (w_strobe) begin
          r_div_cnt   <= '0;
          r_value     <= w_value_nxt;
          r_sweep_cnt <= w_sweep_nxt;
`ifdef DAC_RAMP_BOUNCE_EN
          r_dir       <= w_dir_nxt;
          r_at_min    <= w_at_min_nxt;
`endif
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.err_o         = r_err;
  assign bus.dac_dat_o     = r_dat;
  assign bus.dac_dat_en_o  = r_dat_en;
  assign bus.dac_dat_rst_o = r_dat_rst;

endmodule
`default_nettype wire

// File: tb/tb_dac_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_ramp_gen
// Purpose  : Self-checking bench for dac_ramp_gen against a cycle-indexed
//            expectation timeline built from the sweep rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_ramp_gen;
  localparam int DW = 14;
  localparam int VW = 16;
  localparam int CW = 16;
  localparam int HZ = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  bit exp_en   [HZ];
  bit exp_busy [HZ];
  bit exp_done [HZ];
  bit exp_err  [HZ];
  bit exp_rst  [HZ];
  bit exp_zero [HZ];
  int exp_val  [HZ];
  int seq[$];

  dac_ramp_gen_if #(.DATA_SIZE(DW), .DIV_SIZE(VW), .CNT_SIZE(CW)) bus ();

  dac_ramp_gen #(.DATA_SIZE(DW), .DIV_SIZE(VW), .CNT_SIZE(CW)) dut (
    .dac_clk_i (clk),
    .dac_rst_i (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  // Expected sample list from the sweep rules, capped at lim samples.
  task automatic gen(input int mn, input int mx, input int st, input int cn, input int lim);
    int v;
    int sw;
`ifdef DAC_RAMP_BOUNCE_EN
    bit down;
    bit at_min;
    down   = 1'b0;
    at_min = 1'b0;
`endif
    v  = mn;
    sw = 0;
    seq.delete();
    while (seq.size() < lim) begin
      seq.push_back(v);
`ifdef DAC_RAMP_BOUNCE_EN
      if (at_min) begin
        sw++;
        at_min = 1'b0;
        if (cn != 0 && sw == cn) break;
      end
      if (!down) begin
        if (v + st >= mx) begin v = mx; down = 1'b1; end
        else v = v + st;
      end else begin
        if (v - st <= mn) begin v = mn; down = 1'b0; at_min = 1'b1; end
        else v = v - st;
      end
`else
      if (v + st > mx) begin
        v = mn;
        sw++;
        if (cn != 0 && sw == cn) break;
      end else begin
        v = v + st;
      end
`endif
    end
  endtask

  task automatic pin(input string nm, input int lit[$]);
    chk({nm, "_len"}, seq.size(), lit.size());
    for (int i = 0; i < lit.size() && i < seq.size(); i++) chk(nm, seq[i], lit[i]);
  endtask

  task automatic sched_run(input int e, input int dv, input bit fin);
    int last;
    int c;
    last = e;
    for (int i = 0; i < seq.size(); i++) begin
      c = e + (dv + 1) * (i + 1);
      if (c < HZ) begin
        exp_en[c]  = 1'b1;
        exp_val[c] = seq[i];
        last       = c;
      end
    end
    for (int k = e; k <= last && k < HZ; k++) exp_busy[k] = 1'b1;
    if (fin && last + 1 < HZ) exp_done[last + 1] = 1'b1;
  endtask

  task automatic cut(input int s, input bit is_stop);
    for (int k = s; k < HZ; k++) begin
      exp_en[k]   = 1'b0;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
    if (is_stop) exp_rst[s] = 1'b1;
    else exp_zero[s] = 1'b1;
  endtask

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slots(input int n);
    repeat (n) slot();
  endtask

  task automatic do_start(input int mn, input int mx, input int st, input int dv,
                          input int cn, input bit ok, output int e);
    slot();
    bus.min_i   = DW'(mn);
    bus.max_i   = DW'(mx);
    bus.step_i  = DW'(st);
    bus.div_i   = VW'(dv);
    bus.count_i = CW'(cn);
    bus.start_i = 1'b1;
    e = cyc + 1;
    if (ok) begin
      gen(mn, mx, st, cn, 400);
      sched_run(e, dv, cn != 0);
    end else begin
      exp_err[e] = 1'b1;
    end
    slot();
    bus.start_i = 1'b0;
  endtask

  task automatic stop_at(input int s);
    while (cyc < s - 1) slot();
    bus.stop_i = 1'b1;
    cut(s, 1'b1);
    slot();
    bus.stop_i = 1'b0;
  endtask

  initial begin : compare
    int m_dat;
    m_dat = 0;
    forever begin
      @(negedge clk);
      if (cyc < HZ) begin
        if (exp_zero[cyc]) m_dat = 0;
        if (exp_en[cyc]) m_dat = exp_val[cyc];
        chk("busy",   int'(bus.busy_o),        int'(exp_busy[cyc]));
        chk("done",   int'(bus.done_o),        int'(exp_done[cyc]));
        chk("err",    int'(bus.err_o),         int'(exp_err[cyc]));
        chk("dat_en", int'(bus.dac_dat_en_o),  int'(exp_en[cyc]));
        chk("dat_rst",int'(bus.dac_dat_rst_o), int'(exp_rst[cyc]));
        chk("dat",    int'($signed(bus.dac_dat_o)), m_dat);
      end
    end
  end

  initial begin : stim
    int e;
    int r;
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.min_i   = '0;
    bus.max_i   = '0;
    bus.step_i  = '0;
    bus.div_i   = '0;
    bus.count_i = '0;
    wait_slots(3);
    rst = 1'b0;
    wait_slots(2);

    // Sawtooth, one sample per clock, two sweeps.
    do_start(0, 10, 3, 0, 2, 1'b1, e);
`ifndef DAC_RAMP_BOUNCE_EN
    pin("saw_model", '{0, 3, 6, 9, 0, 3, 6, 9});
`endif
    wait_slots(40);

    // Divided rate with a zero-width span; inputs scrambled mid-run.
    do_start(-8, -8, 1, 4, 3, 1'b1, e);
`ifndef DAC_RAMP_BOUNCE_EN
    pin("div_model", '{-8, -8, -8});
`endif
    bus.min_i   = DW'(0);
    bus.max_i   = DW'(100);
    bus.step_i  = DW'(5);
    bus.div_i   = '0;
    bus.count_i = '0;
    wait_slots(50);

    // Rejected starts.
    do_start(0, 10, 0, 0, 1, 1'b0, e);
    wait_slots(4);
    do_start(5, -5, 1, 0, 1, 1'b0, e);
    wait_slots(4);

    // Free-running sweep, start ignored while running, stop on a due strobe.
    do_start(0, 10, 3, 2, 0, 1'b1, e);
    slot();
    bus.step_i  = '0;
    bus.start_i = 1'b1;
    slot();
    bus.start_i = 1'b0;
    stop_at(e + 9);
    wait_slots(5);

    // Start and stop together while idle: no reaction at all.
    slot();
    bus.step_i  = '0;
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    slot();
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    wait_slots(5);

    // Reset in the middle of a run, then a clean restart.
    do_start(-100, 100, 7, 1, 0, 1'b1, e);
    r = e + 10;
    while (cyc < r - 1) slot();
    rst = 1'b1;
    cut(r, 1'b0);
    slot();
    slot();
    rst = 1'b0;
    do_start(2, 5, 1, 1, 1, 1'b1, e);
    wait_slots(30);

`ifdef DAC_RAMP_BOUNCE_EN
    // Triangle: one full up/down sweep.
    do_start(0, 7, 3, 0, 1, 1'b1, e);
    pin("bounce_model", '{0, 3, 6, 7, 4, 1, 0});
    wait_slots(20);
`endif

    wait_slots(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
